fifo_vc: RTL and testbench
==========================

FIFO_VC -- requirements
Module: fifo_vc

Interface
REQ-001 Parameter DATA_W, default 12, word width: 2-bit class in [11:10], payload in [9:0].
REQ-002 Parameter DEPTH, default 4, number of entries; power of two, at least 2.
REQ-003 Parameter CNT_W, default 3, count width, equal to log2(DEPTH)+1.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 push  in  1  write request; data_in is captured on the same edge.
REQ-007 data_in  in  DATA_W  word from one class output of the class demux.
REQ-008 pop  in  1  read request from the downstream arbiter.
REQ-009 th_af  in  CNT_W  almost-full threshold.
REQ-010 th_ae  in  CNT_W  almost-empty threshold.
REQ-011 data_out  out  DATA_W  registered read word.
REQ-012 valid_out  out  1  one-cycle pulse; data_out carries a newly read word.
REQ-013 full, empty  out  1 each  occupancy status.
REQ-014 almost_full, almost_empty  out  1 each  threshold status.
REQ-015 error  out  1  sticky overflow/underflow indicator.
REQ-016 count  out  CNT_W  current occupancy, 0..DEPTH.

Function
REQ-017 Storage: circular buffer of DEPTH words, write pointer wr_ptr, read pointer rd_ptr; each pointer is log2(DEPTH) bits and wraps from DEPTH-1 to 0.
REQ-018 Push accepted (push=1, full=0): mem[wr_ptr] <= data_in; wr_ptr increments.
REQ-019 Pop accepted (pop=1, empty=0): data_out <= mem[rd_ptr]; valid_out <= 1; rd_ptr increments.
- Read latency: one cycle from the pop edge.
REQ-020 No accepted pop: valid_out <= 0; data_out holds its last value.
REQ-021 Count update: +1 on push only, -1 on pop only, unchanged on both or neither.
REQ-022 Push and pop together while full: both accepted; the pop reads the oldest entry; the push writes into the freed slot; count stays DEPTH; error unchanged.
REQ-023 Push and pop together while empty: push accepted; pop rejected; count becomes 1; valid_out=0; error <= 1.
REQ-024 Push while full without pop: push discarded; memory and wr_ptr unchanged; error <= 1.
REQ-025 Pop while empty without push: no read; valid_out=0; error <= 1.
REQ-026 Flags are combinational on the count register only (no extra latency):
- full = (count==DEPTH)
- empty = (count==0)
- almost_full = (count>=th_af)
- almost_empty = (count<=th_ae)
REQ-027 The threshold inputs are unsigned, compared every cycle, and may change at any time.
REQ-028 error is cleared only by reset.
REQ-029 The class bits are stored unmodified; the block performs no classification.

Reset
REQ-030 While reset=1 at a clock edge, the following are forced regardless of push/pop:
- wr_ptr=0, rd_ptr=0, count=0
- data_out=0, valid_out=0, error=0
REQ-031 Resulting flags after reset: empty=1, full=0; almost flags follow REQ-026.
REQ-032 Memory contents are not reset; they are unobservable until written.
REQ-033 Reset mid-operation discards all stored words; the first pop after reset reads the first word pushed after reset.

Structure
REQ-034 The shared QoS package holds DATA_W, the class-field position [11:10], DEPTH and CNT_W; the demux, the four FIFO instances and the arbiter use the same constants.
REQ-035 One sub-module, mem_vc: a DEPTH x DATA_W register array with synchronous write and combinational read.
- Pointer, count and flag logic stay in fifo_vc.
REQ-036 Four instances of fifo_vc, one per class output of the demux, form the per-class buffering stage.

Verification
REQ-037 Reset, then push 0x001, 0x402, 0x803, 0xC04 on consecutive cycles -> count=4, full=1, error=0; four pops -> valid_out pulses with 0x001, 0x402, 0x803, 0xC04, each one cycle after its pop; then empty=1.
REQ-038 Full, then push 0x555 alone -> error=1, count=4; the next four pops return the original four words; 0x555 never appears.
REQ-039 Empty, push=1 and pop=1 with data 0x123 -> count=1, valid_out=0, error=1; the next pop returns 0x123.
REQ-040 Full, push=1 and pop=1 with data 0x7AA -> data_out=oldest word, count=4, error=0; after 3 more pops the 4th pop returns 0x7AA.
REQ-041 th_af=3, th_ae=1; push 3 words one per cycle -> almost_empty=1 at counts 0-1, almost_full=1 from count 3.
- Then change th_af to 4 -> almost_full=0 in the same cycle.
REQ-042 Wrap-around: run 10 push/pop cycles at count=2, then reset asserted for one cycle mid-stream -> all outputs equal REQ-030 values.
- Next push 0x0AB then pop returns 0x0AB.

Source files
------------

// File: rtl/fifo_vc_pkg.sv
// Shared QoS constants: word layout, per-class FIFO depth and count width.
package fifo_vc_pkg;

  localparam int QOS_DATA_W = 12;
  localparam int QOS_CLS_HI = 11;
  localparam int QOS_CLS_LO = 10;
  localparam int QOS_DEPTH  = 4;
  localparam int QOS_CNT_W  = 3;

  // Extract the 2-bit class field from a word.
  function automatic logic [QOS_CLS_HI-QOS_CLS_LO:0] word_class(
    input logic [QOS_DATA_W-1:0] word
  );
    return word[QOS_CLS_HI:QOS_CLS_LO];
  endfunction

endpackage

// File: rtl/mem_vc.sv
// Per-class storage array: synchronous write, combinational read, no reset.
module mem_vc
  import fifo_vc_pkg::*;
#(
  parameter int DATA_W = QOS_DATA_W,
  parameter int DEPTH  = QOS_DEPTH,
  parameter int PTR_W  = $clog2(QOS_DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [PTR_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [PTR_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_r [DEPTH];

  // Write the addressed entry when enabled; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/fifo_vc.sv
// Per-class FIFO: circular buffer with occupancy count, threshold flags and
// a sticky overflow/underflow indicator. Read data is registered.
module fifo_vc
  import fifo_vc_pkg::*;
#(
  parameter int DATA_W = QOS_DATA_W,
  parameter int DEPTH  = QOS_DEPTH,
  parameter int CNT_W  = QOS_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] data_in,
  input  logic              pop,
  input  logic [CNT_W-1:0]  th_af,
  input  logic [CNT_W-1:0]  th_ae,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              error,
  output logic [CNT_W-1:0]  count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic [DATA_W-1:0] data_out_r;
  logic              valid_r;
  logic              error_r;

  logic              full_s;
  logic              empty_s;
  logic              push_ok_s;
  logic              pop_ok_s;
  logic              err_set_s;
  logic [CNT_W-1:0]  count_nxt_s;
  logic [DATA_W-1:0] rd_word_s;

  // Status flags and request acceptance, derived from the count register only.
  // A push into a full FIFO is accepted when a pop frees a slot the same cycle.
  always_comb begin
    full_s    = (count_r == CNT_W'(DEPTH));
    empty_s   = (count_r == {CNT_W{1'b0}});
    pop_ok_s  = pop & ~empty_s;
    push_ok_s = push & (~full_s | pop_ok_s);
    err_set_s = (push & ~push_ok_s) | (pop & ~pop_ok_s);
  end

  // Next occupancy: up on push only, down on pop only, otherwise held.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_nxt_s = count_r + CNT_W'(1);
      2'b01:   count_nxt_s = count_r - CNT_W'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointer, count, read-data and error state; reset forces the idle state.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      count_r    <= {CNT_W{1'b0}};
      data_out_r <= {DATA_W{1'b0}};
      valid_r    <= 1'b0;
      error_r    <= 1'b0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r   <= rd_ptr_r + PTR_W'(1);
        data_out_r <= rd_word_s;
      end
      count_r <= count_nxt_s;
      valid_r <= pop_ok_s;
      if (err_set_s) begin
        error_r <= 1'b1;
      end
    end
  end

  mem_vc #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (push_ok_s),
    .waddr (wr_ptr_r),
    .wdata (data_in),
    .raddr (rd_ptr_r),
    .rdata (rd_word_s)
  );

  assign data_out     = data_out_r;
  assign valid_out    = valid_r;
  assign full         = full_s;
  assign empty        = empty_s;
  assign almost_full  = (count_r >= th_af);
  assign almost_empty = (count_r <= th_ae);
  assign error        = error_r;
  assign count        = count_r;

endmodule

// File: tb/tb_fifo_vc.sv
// Scoreboard bench for fifo_vc: a queue-based reference model predicts
// occupancy, flags, error and read data; a negedge monitor compares.
module tb_fifo_vc;
  import fifo_vc_pkg::*;

  localparam int DW = QOS_DATA_W;
  localparam int DP = QOS_DEPTH;
  localparam int CW = QOS_CNT_W;

  logic          clk = 1'b0;
  logic          reset, push, pop;
  logic [DW-1:0] data_in;
  logic [CW-1:0] th_af, th_ae;
  logic [DW-1:0] data_out;
  logic          valid_out, full, empty, almost_full, almost_empty, error;
  logic [CW-1:0] count;

  always #5 clk = ~clk;

  fifo_vc #(.DATA_W(DW), .DEPTH(DP), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .push(push), .data_in(data_in), .pop(pop),
    .th_af(th_af), .th_ae(th_ae), .data_out(data_out), .valid_out(valid_out),
    .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .error(error), .count(count)
  );

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] mdl_q [$];   // words held by the FIFO, oldest first
  logic [DW-1:0] exp_q [$];   // read words awaiting a valid_out pulse
  logic          m_err   = 1'b0;
  logic          m_valid = 1'b0;
  logic [DW-1:0] m_dout  = '0;
  bit            mon_en  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h time=%0t", nm, act, exp, $time);
    end
  endtask

  // Apply one cycle of stimulus and advance the reference model at the edge.
  task automatic cycle(input logic p, input logic q, input logic [DW-1:0] d,
                       input logic r = 1'b0);
    bit pop_ok, push_ok;
    push = p; pop = q; data_in = d; reset = r;
    @(posedge clk);
    if (r) begin
      mdl_q.delete();
      m_err = 1'b0; m_valid = 1'b0; m_dout = '0;
    end else begin
      pop_ok  = q && (mdl_q.size() > 0);
      push_ok = p && ((mdl_q.size() < DP) || pop_ok);
      if (pop_ok) begin
        m_dout = mdl_q.pop_front();
        exp_q.push_back(m_dout);
      end
      m_valid = pop_ok;
      if (push_ok) mdl_q.push_back(d);
      if ((p && !push_ok) || (q && !pop_ok)) m_err = 1'b1;
    end
    #1;
    push = 1'b0; pop = 1'b0; reset = 1'b0;
  endtask

  // Monitor: compare every observable output against the model each cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("count", 32'(count), 32'(mdl_q.size()));
      chk("full", 32'(full), 32'(mdl_q.size() == DP));
      chk("empty", 32'(empty), 32'(mdl_q.size() == 0));
      chk("almost_full", 32'(almost_full), 32'(mdl_q.size() >= int'(th_af)));
      chk("almost_empty", 32'(almost_empty), 32'(mdl_q.size() <= int'(th_ae)));
      chk("error", 32'(error), 32'(m_err));
      chk("valid_out", 32'(valid_out), 32'(m_valid));
      if (valid_out === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_read actual=0x%0h required=no_read", data_out);
        end else begin
          chk("read_data", 32'(data_out), 32'(exp_q.pop_front()));
        end
      end else begin
        chk("data_hold", 32'(data_out), 32'(m_dout));
      end
    end
  end

  initial begin
    logic [DW-1:0] w4 [4];
    w4[0] = 12'h001; w4[1] = 12'h402; w4[2] = 12'h803; w4[3] = 12'hC04;
    push = 1'b0; pop = 1'b0; reset = 1'b1; data_in = '0;
    th_af = 3'd3; th_ae = 3'd1;

    cycle(1'b0, 1'b0, '0, 1'b1);
    cycle(1'b0, 1'b0, '0, 1'b1);
    mon_en = 1'b1;

    // Fill then drain in order.
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, w4[i]);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, '0);
    cycle(1'b0, 1'b0, '0);

    // Overflow: extra word discarded, error sticky.
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, w4[i]);
    cycle(1'b1, 1'b0, 12'h555);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, '0);
    cycle(1'b0, 1'b0, '0);

    // Simultaneous push/pop while empty.
    cycle(1'b0, 1'b0, '0, 1'b1);
    cycle(1'b1, 1'b1, 12'h123);
    cycle(1'b0, 1'b1, '0);
    cycle(1'b0, 1'b0, '0);

    // Simultaneous push/pop while full.
    cycle(1'b0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, w4[i]);
    cycle(1'b1, 1'b1, 12'h7AA);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, '0);
    cycle(1'b0, 1'b0, '0);

    // Thresholds, including a change with no clock edge in between.
    cycle(1'b0, 1'b0, '0, 1'b1);
    th_af = 3'd3; th_ae = 3'd1;
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, DW'(12'h100 + i));
    @(negedge clk);
    #1 th_af = 3'd4;
    @(negedge clk);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, '0);

    // Wrap-around at count 2, reset mid-stream, then recovery.
    cycle(1'b1, 1'b0, 12'h011);
    cycle(1'b1, 1'b0, 12'h022);
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, DW'($urandom));
    cycle(1'b1, 1'b1, 12'hFFF, 1'b1);
    cycle(1'b1, 1'b0, 12'h0AB);
    cycle(1'b0, 1'b1, '0);
    cycle(1'b0, 1'b0, '0);

    // Randomized traffic with moving thresholds and rare resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        th_af = CW'($urandom_range(0, 7));
        th_ae = CW'($urandom_range(0, 7));
      end
      cycle(1'(($urandom_range(0, 99) < 55)), 1'(($urandom_range(0, 99) < 50)),
            DW'($urandom), 1'(($urandom_range(0, 79) == 0)));
    end
    cycle(1'b0, 1'b0, '0);
    @(negedge clk);
    #1;
    chk("reads_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
